instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: groups the instruction-memory bus and the fetch/datapath handshake.
// Ports: mem_req/mem_addr/mem_ready/mem_rvalid/mem_rdata (memory side),
//        PCSrc/PCTarget (redirect), Instr/PC/instr_valid/instr_ready (datapath side).
interface instr_fetch_if;
  // memory side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // redirect from the datapath
  logic        PCSrc;
  logic [31:0] PCTarget;
  // delivered instruction stream
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        instr_valid;
  logic        instr_ready;

  // master: the fetch unit
  modport master (
    output mem_req, mem_addr, Instr, PC, instr_valid,
    input  mem_ready, mem_rvalid, mem_rdata, PCSrc, PCTarget, instr_ready
  );

  // slave: memory plus datapath seen as one environment
  modport slave (
    input  mem_req, mem_addr, Instr, PC, instr_valid,
    output mem_ready, mem_rvalid, mem_rdata, PCSrc, PCTarget, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetches words from instruction memory into a 2-entry {PC, Instr} FIFO, with redirect.
// Latency: request accepted in cycle N, earliest response N+1, instr_valid in N+2; one request in flight.
// Backpressure: instr_ready=0 lets the FIFO fill to 2 entries, after which mem_req stays low.
// Ports: clk, reset (async active-low), bus (instr_fetch_if.master: memory bus, redirect, instr stream).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  // Held low through the first edge after reset so mem_req is 0 while reset is asserted
  // yet still derives from registered state only.
  logic        run;

  // FIFO: entry 0 is the head
  logic [1:0]  count;
  logic [31:0] pc0, in0, pc1, in1;

  logic accept;
  logic push;
  logic pop;
  logic mem_req;

  // ---------------------------------------------------------------------------
  // FSM next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    mem_req = run && (state == REQ) && (count != 2'd2);
    accept  = mem_req && bus.mem_ready;
    pop     = (count != 2'd0) && bus.instr_ready && !bus.PCSrc;

    case (state)
      REQ: begin
        // An acceptance that coincides with a redirect is already stale.
        if (accept) state_nxt = bus.PCSrc ? DROP : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt = REQ;
          push      = !bus.PCSrc;
        end else if (bus.PCSrc) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.mem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, fetch address and in-flight address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= REQ;
      run      <= 1'b0;
      fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      req_pc   <= RESET_PC & 32'hFFFF_FFFC;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (bus.PCSrc)
        fetch_pc <= bus.PCTarget & 32'hFFFF_FFFC;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;   // wraps naturally at 2^32
      if (accept)
        req_pc <= fetch_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO; a redirect flushes it and overrides push/pop.
  // A push never meets a full FIFO: requests stop at occupancy 2 and only one is in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
      pc0   <= 32'h0;
      in0   <= NOP;
      pc1   <= 32'h0;
      in1   <= NOP;
    end else if (bus.PCSrc) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            pc0 <= req_pc;
            in0 <= bus.mem_rdata;
          end else begin
            pc1 <= req_pc;
            in1 <= bus.mem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0   <= pc1;
          in0   <= in1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word goes behind whatever remains
          if (count == 2'd1) begin
            pc0 <= req_pc;
            in0 <= bus.mem_rdata;
          end else begin
            pc0 <= pc1;
            in0 <= in1;
            pc1 <= req_pc;
            in1 <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.Instr       = (count != 2'd0) ? in0 : NOP;
  assign bus.PC          = (count != 2'd0) ? pc0 : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a latency-programmable memory model.
// A second instance with RESET_PC=FFFF_FFFC covers address wrap.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  instr_fetch_if wbus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk   (clk),
    .reset (rst_n),
    .bus   (wbus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  sb[$];
  pend_t pend[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int prev_cyc = 0;
  logic have_prev = 1'b0;
  logic gap_on    = 1'b0;
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_addr = 32'h0;
  logic [31:0] ovr_data = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0: word = 32'h0050_0113;
      32'h4: word = 32'h00C0_0193;
      32'h8: word = 32'hFF71_8393;
      32'hC: word = 32'h0023_E233;
      default: word = {a[23:0] ^ 24'h5A_5A5A, 8'h13};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word(pc);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.PCSrc = 1'b0;
    repeat (3) step();
    pend.delete();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for mem_req at a falling edge, then checks the address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req) found = 1'b1;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (found) check(tag, bus.mem_addr, exp_addr);
  endtask

  // Waits (bounded) until n acceptances have been observed.
  task automatic wait_accept(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 30 && seen < n; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_ready) seen++;
    end
    check(tag, seen, n);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    check(tag, sb.size(), 0);
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: accept at falling edge, respond lat cycles later
  initial forever begin
    pend_t p;
    @(negedge clk);
    if (rst_n && bus.mem_req && bus.mem_ready) begin
      p.addr = bus.mem_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
    end
  end

  initial begin
    pend_t p;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = (ovr_en && p.addr == ovr_addr) ? ovr_data : word(p.addr);
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // 1-cycle memory for the wrap instance
  initial begin
    logic        wacc;
    logic [31:0] wa;
    wbus.mem_rvalid = 1'b0;
    wbus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      wacc = rst_n && wbus.mem_req && wbus.mem_ready;
      wa   = wbus.mem_addr;
      @(posedge clk);
      #1;
      wbus.mem_rvalid = wacc;
      wbus.mem_rdata  = word(wa);
    end
  end

  // consumer side: every pop is compared against the scoreboard head
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.PCSrc) begin
      if (sb.size() == 0) begin
        check("extra_pop_pc", bus.PC, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("pop_pc", bus.PC, e.pc);
        check("pop_instr", bus.Instr, e.instr);
        if (gap_on && have_prev) check("pop_gap", cyc - prev_cyc, 2);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.mem_ready    = 1'b1;
    bus.PCSrc        = 1'b0;
    bus.PCTarget     = 32'h0;
    bus.instr_ready  = 1'b0;
    wbus.mem_ready   = 1'b1;
    wbus.PCSrc       = 1'b0;
    wbus.PCTarget    = 32'h0;
    wbus.instr_ready = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.Instr, 32'h0000_0013);
    check("rst_pc", bus.PC, 32'h0);
    check("rst_wrap_addr", wbus.mem_addr, 32'hFFFF_FFFC);
    check("rst_wrap_req", wbus.mem_req, 1'b0);

    // sequential fetch, 1-cycle memory, two cycles per instruction
    step();
    lat = 1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    gap_on    = 1'b1;
    have_prev = 1'b0;
    do_reset();
    drain("seq_drain");
    bus.instr_ready = 1'b0;
    gap_on = 1'b0;

    // backpressure: fill both entries, stall, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    repeat (12) step();
    @(negedge clk);
    check("bp_valid", bus.instr_valid, 1'b1);
    check("bp_head_pc", bus.PC, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("bp_req_low", bus.mem_req, 1'b0);
      @(negedge clk);
    end
    step();
    bus.instr_ready = 1'b1;
    drain("bp_drain");
    bus.instr_ready = 1'b0;

    // redirect while waiting: lat 2 goes through DROP, lat 1 hits response same cycle
    ovr_en   = 1'b1;
    ovr_addr = 32'h0;
    ovr_data = 32'h0023_E233;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] tgt;
      lat = (k == 0) ? 2 : 1;
      tgt = (k == 0) ? 32'h40 : 32'h80;
      bus.instr_ready = 1'b1;
      do_reset();
      wait_accept("rw_accept", 1);
      step();
      bus.PCSrc    = 1'b1;
      bus.PCTarget = tgt;
      step();
      bus.PCSrc = 1'b0;
      push_exp(tgt);
      if (lat == 2) begin
        @(negedge clk);
        check("rw_drop_req", bus.mem_req, 1'b0);
      end
      wait_req("rw_next_addr", tgt);
      step();
      drain("rw_drain");
      bus.instr_ready = 1'b0;
    end
    ovr_en = 1'b0;

    // redirect in the acceptance cycle with a misaligned target
    lat = 1;
    bus.mem_ready   = 1'b0;
    bus.instr_ready = 1'b1;
    do_reset();
    wait_req("ra_first_addr", 32'h0);
    step();
    bus.mem_ready = 1'b1;
    bus.PCSrc     = 1'b1;
    bus.PCTarget  = 32'h103;
    step();
    bus.PCSrc = 1'b0;
    push_exp(32'h100);
    @(negedge clk);
    check("ra_drop_req", bus.mem_req, 1'b0);
    wait_req("ra_next_addr", 32'h100);
    step();
    drain("ra_drain");
    bus.instr_ready = 1'b0;

    // asynchronous reset pulse between edges while waiting on a response
    lat = 2;
    do_reset();
    wait_accept("ar_accept", 2);
    step();
    check("ar_pre_valid", bus.instr_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_mem_req", bus.mem_req, 1'b0);
    check("ar_mem_addr", bus.mem_addr, 32'h0);
    check("ar_valid", bus.instr_valid, 1'b0);
    check("ar_instr", bus.Instr, 32'h0000_0013);
    check("ar_pc", bus.PC, 32'h0);
    #1 rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    push_exp(32'h0);
    wait_req("ar_restart_addr", 32'h0);
    step();
    drain("ar_drain");
    bus.instr_ready = 1'b0;

    // wrap instance: has been filling since the last reset with instr_ready=0
    repeat (4) step();
    @(negedge clk);
    check("wrap_valid", wbus.instr_valid, 1'b1);
    check("wrap_pc0", wbus.PC, 32'hFFFF_FFFC);
    check("wrap_instr0", wbus.Instr, word(32'hFFFF_FFFC));
    check("wrap_full_req", wbus.mem_req, 1'b0);
    step();
    wbus.instr_ready = 1'b1;
    step();
    wbus.instr_ready = 1'b0;
    @(negedge clk);
    check("wrap_pc1", wbus.PC, 32'h0);
    check("wrap_instr1", wbus.Instr, word(32'h0));

    step();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
